// File: rtl/comms_pkg.sv
// Shared definitions for the UART receive path.
// Provides the frame FSM state encoding and the half-bit sample offset helper.
package comms_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  // Cycles from start-bit detection to the first (mid-bit) sample.
  function automatic int unsigned half_bit(input int unsigned ratio);
    return ratio / 2;
  endfunction

endpackage

// File: rtl/recv_if.sv
// Serial-in / word-out bundle of the multi-frame UART receiver.
//   rx_in     : serial line, idle high
//   data_out  : assembled word
//   valid_out : one-cycle strobe, data_out valid
//   error_out : one-cycle strobe, framing error or timeout discard
//   busy_out  : frame in progress or partial word held
interface recv_if #(
  parameter int unsigned DATA_SIZE = 16
);
  logic                 rx_in;
  logic [DATA_SIZE-1:0] data_out;
  logic                 valid_out;
  logic                 error_out;
  logic                 busy_out;

  modport master (
    input  rx_in,
    output data_out, valid_out, error_out, busy_out
  );

  modport slave (
    output rx_in,
    input  data_out, valid_out, error_out, busy_out
  );
endinterface

// File: rtl/recv_uart_rx_frame.sv
// Single-frame UART deserialiser (start, FRAME_SIZE data bits LSB first, stop).
// Expects an already synchronised line.
//   clk_in, rst_in : clock, synchronous active-low reset
//   rxs            : synchronised serial line
//   frame_out      : received frame, updated with frame_done
//   frame_done     : one-cycle pulse, good stop bit
//   frame_err      : one-cycle pulse, stop bit sampled low
//   active         : FSM is outside IDLE
module uart_rx_frame
  import comms_pkg::*;
#(
  parameter int unsigned CLK_BAUD_RATIO = 25,
  parameter int unsigned FRAME_SIZE     = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rxs,
  output logic [FRAME_SIZE-1:0] frame_out,
  output logic                  frame_done,
  output logic                  frame_err,
  output logic                  active
);

  localparam int unsigned CNT_W = $clog2(CLK_BAUD_RATIO);
  localparam int unsigned IDX_W = (FRAME_SIZE > 1) ? $clog2(FRAME_SIZE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_BAUD_RATIO - 1);
  // Loaded on detection so the start-bit sample lands half a bit later.
  localparam logic [CNT_W-1:0] CNT_START = CNT_W'(CLK_BAUD_RATIO - half_bit(CLK_BAUD_RATIO));
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(FRAME_SIZE - 1);

  rx_state_t             state;
  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic [FRAME_SIZE-1:0] shreg;
  logic                  sample;

  assign sample = (cnt == CNT_LAST);

  // Frame FSM with bit-period counter and shift register.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      frame_out  <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      active     <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxs) begin
            state  <= START;
            cnt    <= CNT_START;
            active <= 1'b1;
          end
        end
        START: begin
          if (sample) begin
            cnt <= '0;
            if (rxs) begin
              state  <= IDLE;
              active <= 1'b0;
            end else begin
              state <= DATA;
              idx   <= '0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (sample) begin
            cnt   <= '0;
            shreg <= {rxs, shreg[FRAME_SIZE-1:1]};
            idx   <= idx + IDX_W'(1);
            if (idx == IDX_LAST) state <= STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STOP: begin
          // Resolve at mid-stop so a back-to-back start bit is not missed.
          if (sample) begin
            cnt    <= '0;
            state  <= IDLE;
            active <= 1'b0;
            if (rxs) begin
              frame_done <= 1'b1;
              frame_out  <= shreg;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state  <= IDLE;
          active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/recv.sv
// Multi-frame UART receiver: assembles FRAMES consecutive frames into one word.
//   clk_in, rst_in : clock, synchronous active-low reset
//   bus            : recv_if master (rx_in in; data/valid/error/busy out)
module recv
  import comms_pkg::*;
#(
  parameter int unsigned CLK_BAUD_RATIO = 25,
  parameter int unsigned FRAME_SIZE     = 8,
  parameter int unsigned FRAMES         = 2,
  parameter int unsigned TIMEOUT_BAUDS  = 20
) (
  input  logic    clk_in,
  input  logic    rst_in,
  recv_if.master  bus
);

  localparam int unsigned DATA_SIZE = FRAME_SIZE * FRAMES;
  localparam int unsigned FC_W      = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int unsigned TO_LIMIT  = TIMEOUT_BAUDS * CLK_BAUD_RATIO;
  localparam int unsigned TO_W      = (TO_LIMIT > 1) ? $clog2(TO_LIMIT) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAMES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_LIMIT - 1);

  logic                  rx_s1, rxs, armed;
  logic [1:0]            fill;
  logic                  rx_gated;
  logic [FRAME_SIZE-1:0] frame;
  logic                  frame_done, frame_err, active;
  logic [DATA_SIZE-1:0]  word_q, word_c, data_q;
  logic [FC_W-1:0]       frame_cnt;
  logic [TO_W-1:0]       to_cnt;
  logic                  valid_q, error_q, busy_q;
  logic                  start_det_c, to_run_c, to_fire_c;

  // Until armed the FSM sees an idle line, so no start can be detected.
  assign rx_gated = rxs | ~armed;

  uart_rx_frame #(
    .CLK_BAUD_RATIO (CLK_BAUD_RATIO),
    .FRAME_SIZE     (FRAME_SIZE)
  ) u_frame (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rxs        (rx_gated),
    .frame_out  (frame),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .active     (active)
  );

  // Word with the new frame merged into its slot; timeout control terms.
  always_comb begin
    word_c = word_q;
    word_c[32'(frame_cnt) * FRAME_SIZE +: FRAME_SIZE] = frame;
    start_det_c = armed && !rxs && !active;
    to_run_c    = (TO_LIMIT != 0) && !active && ((frame_cnt != '0) || frame_done);
    to_fire_c   = to_run_c && !frame_done && !frame_err && (to_cnt == TO_LAST);
  end

  // Synchroniser, arming, assembly, timeout and registered outputs.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      rx_s1     <= 1'b1;
      rxs       <= 1'b1;
      fill      <= '0;
      armed     <= 1'b0;
      word_q    <= '0;
      data_q    <= '0;
      frame_cnt <= '0;
      to_cnt    <= '0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      rx_s1 <= bus.rx_in;
      rxs   <= rx_s1;
      // fill[1] marks that rxs now carries a real line sample, not the reset value.
      fill  <= {fill[0], 1'b1};
      if (fill[1] && rxs) armed <= 1'b1;

      valid_q <= 1'b0;
      error_q <= 1'b0;
      if (frame_err) begin
        frame_cnt <= '0;
        word_q    <= '0;
        error_q   <= 1'b1;
      end else if (frame_done) begin
        if (frame_cnt == FC_LAST) begin
          data_q    <= word_c;
          valid_q   <= 1'b1;
          frame_cnt <= '0;
          word_q    <= '0;
        end else begin
          word_q    <= word_c;
          frame_cnt <= frame_cnt + FC_W'(1);
        end
      end else if (to_fire_c) begin
        frame_cnt <= '0;
        word_q    <= '0;
        error_q   <= 1'b1;
      end

      if (start_det_c || !to_run_c || to_fire_c) to_cnt <= '0;
      else                                       to_cnt <= to_cnt + TO_W'(1);

      busy_q <= active || (frame_cnt != '0);
    end
  end

  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.error_out = error_q;
  assign bus.busy_out  = busy_q;

endmodule

// File: tb/tb_recv.sv
// Directed bench for recv: instance A uses defaults (ratio 25, 2 frames),
// instance B uses ratio 4, 4 frames. Lines are driven on falling clock edges.
module tb_recv;

  localparam int unsigned RA = 25;
  localparam int unsigned RB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  recv_if #(.DATA_SIZE(16)) ifa ();
  recv_if #(.DATA_SIZE(32)) ifb ();

  recv #(.CLK_BAUD_RATIO(RA), .FRAME_SIZE(8), .FRAMES(2), .TIMEOUT_BAUDS(20))
    dut_a (.clk_in(clk), .rst_in(rst_n), .bus(ifa));
  recv #(.CLK_BAUD_RATIO(RB), .FRAME_SIZE(8), .FRAMES(4), .TIMEOUT_BAUDS(20))
    dut_b (.clk_in(clk), .rst_in(rst_n), .bus(ifb));

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  int va_n = 0, ea_n = 0, vb_n = 0, eb_n = 0, both_n = 0;
  int unsigned va_cyc = 0, ea_cyc = 0, vb_cyc = 0;

  // Pulse monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (ifa.valid_out) begin va_n++; va_cyc = cyc; end
    if (ifa.error_out) begin ea_n++; ea_cyc = cyc; end
    if (ifb.valid_out) begin vb_n++; vb_cyc = cyc; end
    if (ifb.error_out) eb_n++;
    if ((ifa.valid_out && ifa.error_out) || (ifb.valid_out && ifb.error_out)) both_n++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_rx(input int inst, input logic v);
    if (inst == 0) ifa.rx_in = v;
    else           ifb.rx_in = v;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input int inst, input logic [7:0] b, input logic stop_bit);
    int r;
    r = (inst == 0) ? int'(RA) : int'(RB);
    set_rx(inst, 1'b0);
    idle(r);
    for (int i = 0; i < 8; i++) begin
      set_rx(inst, b[i]);
      idle(r);
    end
    set_rx(inst, stop_bit);
    idle(r);
    set_rx(inst, 1'b1);
  endtask

  int unsigned c0;
  int v0, e0;

  initial begin
    ifa.rx_in = 1'b1;
    ifb.rx_in = 1'b1;
    rst_n = 1'b0;
    idle(4);
    check("rst_data", 32'(ifa.data_out), 32'h0);
    check("rst_valid", 32'(ifa.valid_out), 32'h0);
    check("rst_error", 32'(ifa.error_out), 32'h0);
    check("rst_busy", 32'(ifa.busy_out), 32'h0);
    check("rst_data_b", ifb.data_out, 32'h0);
    rst_n = 1'b1;
    idle(10);

    // Two back-to-back frames; valid 1 cycle after the second stop sample (491 cycles).
    c0 = cyc; v0 = va_n; e0 = ea_n;
    send_frame(0, 8'h34, 1'b1);
    send_frame(0, 8'h12, 1'b1);
    idle(20);
    check("w1_data", 32'(ifa.data_out), 32'h1234);
    check("w1_nvalid", 32'(va_n - v0), 32'd1);
    check("w1_latency", va_cyc - c0, 32'd491);
    check("w1_noerr", 32'(ea_n - e0), 32'd0);
    check("w1_busy", 32'(ifa.busy_out), 32'h0);

    // Good frame then framing error: partial word discarded.
    v0 = va_n; e0 = ea_n;
    send_frame(0, 8'h77, 1'b1);
    send_frame(0, 8'hA5, 1'b0);
    idle(40);
    check("ferr_nerr", 32'(ea_n - e0), 32'd1);
    check("ferr_novalid", 32'(va_n - v0), 32'd0);
    check("ferr_busy", 32'(ifa.busy_out), 32'h0);
    check("ferr_data_held", 32'(ifa.data_out), 32'h1234);
    send_frame(0, 8'h0F, 1'b1);
    send_frame(0, 8'hF0, 1'b1);
    idle(20);
    check("w2_data", 32'(ifa.data_out), 32'hF00F);
    check("w2_nvalid", 32'(va_n - v0), 32'd1);

    // 12-cycle glitch: false start, no pulses.
    v0 = va_n; e0 = ea_n;
    set_rx(0, 1'b0);
    idle(8);
    check("glitch_busy_hi", 32'(ifa.busy_out), 32'h1);
    idle(4);
    set_rx(0, 1'b1);
    idle(40);
    check("glitch_noerr", 32'(ea_n - e0), 32'd0);
    check("glitch_novalid", 32'(va_n - v0), 32'd0);
    check("glitch_busy", 32'(ifa.busy_out), 32'h0);

    // Single frame then idle: timeout 500 cycles after the stop sample (cycle 740).
    c0 = cyc; v0 = va_n; e0 = ea_n;
    send_frame(0, 8'h55, 1'b1);
    idle(100);
    check("to_busy_held", 32'(ifa.busy_out), 32'h1);
    check("to_not_yet", 32'(ea_n - e0), 32'd0);
    idle(400);
    check("to_nerr", 32'(ea_n - e0), 32'd1);
    check("to_time", ea_cyc - c0, 32'd740);
    check("to_novalid", 32'(va_n - v0), 32'd0);
    check("to_busy", 32'(ifa.busy_out), 32'h0);
    send_frame(0, 8'h01, 1'b1);
    send_frame(0, 8'h02, 1'b1);
    idle(20);
    check("w3_data", 32'(ifa.data_out), 32'h0201);
    check("w3_nvalid", 32'(va_n - v0), 32'd1);

    // Reset mid-frame with line held low: must wait for the line to go high.
    set_rx(0, 1'b0);
    idle(50);
    rst_n = 1'b0;
    idle(3);
    check("mrst_data", 32'(ifa.data_out), 32'h0);
    check("mrst_busy", 32'(ifa.busy_out), 32'h0);
    rst_n = 1'b1;
    v0 = va_n; e0 = ea_n;
    idle(75);
    check("mrst_nostart", 32'(ifa.busy_out), 32'h0);
    check("mrst_noerr", 32'(ea_n - e0), 32'd0);
    check("mrst_novalid", 32'(va_n - v0), 32'd0);
    set_rx(0, 1'b1);
    idle(30);
    send_frame(0, 8'hEF, 1'b1);
    send_frame(0, 8'hBE, 1'b1);
    idle(20);
    check("w4_data", 32'(ifa.data_out), 32'hBEEF);
    check("w4_nvalid", 32'(va_n - v0), 32'd1);

    // Instance B: 4 frames at ratio 4; valid at cycle 162.
    c0 = cyc; v0 = vb_n; e0 = eb_n;
    send_frame(1, 8'h11, 1'b1);
    send_frame(1, 8'h22, 1'b1);
    send_frame(1, 8'h33, 1'b1);
    send_frame(1, 8'h44, 1'b1);
    idle(20);
    check("b_data", ifb.data_out, 32'h44332211);
    check("b_nvalid", 32'(vb_n - v0), 32'd1);
    check("b_latency", vb_cyc - c0, 32'd162);
    check("b_noerr", 32'(eb_n - e0), 32'd0);

    check("valid_error_overlap", 32'(both_n), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
